// File: rtl/pattern_1101_tx_pkg.sv
// -----------------------------------------------------------------------------
// pattern_1101_tx_pkg
// Shared definitions for the serial pattern transmitter and the bit-pattern
// detector FSMs it drives:
//   - state_t        : transmitter state encodings
//   - DEFAULT_PATTERN: the word sent when use_data=0
//   - `BIT_ONE / `BIT_ZERO / `BIT_NONE : serial line symbol constants
// Optional feature macro used by the transmitter: PATTERN_TX_PREAMBLE_EN.
// -----------------------------------------------------------------------------
`ifndef PATTERN_DEFS_BITS
`define PATTERN_DEFS_BITS
`define BIT_ONE  1'b1
`define BIT_ZERO 1'b0
`define BIT_NONE 1'bx
`endif

package pattern_1101_tx_pkg;

    // Gray-like encodings shared with the detector benches.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_PRE  = 3'b001,
        ST_SEND = 3'b011,
        ST_GAP  = 3'b010,
        ST_DONE = 3'b110
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

// File: rtl/pattern_1101_tx_shreg.sv
// -----------------------------------------------------------------------------
// pattern_shreg
// WIDTH-bit parallel-load, MSB-first shift register. Load has priority over
// shift; zeros are shifted in at the LSB end.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-low clear
//   i_load   in   load i_data
//   i_shift  in   shift left by one
//   i_data   in   WIDTH-bit parallel load value
//   o_msb    out  current MSB (the bit on the line)
// -----------------------------------------------------------------------------
module pattern_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_data;

    // NOTE: sequential state is always written with <= so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= r_data << 1;
        end
    end

    assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/pattern_1101_tx.sv
// -----------------------------------------------------------------------------
// pattern_1101_tx
// Serial pattern transmitter. On an accepted start it sends a WIDTH-bit word
// MSB-first on y, repeated max(reps,1) times with GAP_BITS zeros between
// copies, then pulses done for one cycle. The word is PATTERN (use_data=0)
// or data_in (use_data=1); word, reps and use_data are latched at acceptance.
// Optional feature: define PATTERN_TX_PREAMBLE_EN to prepend PRE_BITS zero
// cycles (busy, not valid) before the first copy.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-low reset, forces IDLE
//   start     in   transfer request, sampled only in IDLE
//   use_data  in   1: send data_in, 0: send PATTERN
//   data_in   in   WIDTH-bit word
//   reps      in   copy count (0 treated as 1)
//   y         out  serial bit, 0 unless a word bit is being sent
//   valid     out  y carries a word bit
//   busy      out  transfer in progress (excluding the done cycle)
//   done      out  one-cycle end-of-transfer pulse
// -----------------------------------------------------------------------------
module pattern_1101_tx
    import pattern_1101_tx_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] PATTERN  = DEFAULT_PATTERN,
    parameter int               GAP_BITS = 2,
    parameter int               REPS_W   = 4
`ifdef PATTERN_TX_PREAMBLE_EN
    ,
    parameter int               PRE_BITS = 3
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              use_data,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [REPS_W-1:0] reps,
    output logic              y,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int GAP_W = $clog2(GAP_BITS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [BIT_W-1:0]   r_bitcnt;
    logic [GAP_W-1:0]   r_gapcnt;
    logic [REPS_W-1:0]  r_repcnt;   // copies still to send, including the current one
    logic [WIDTH-1:0]   r_word;     // latched word, reloaded for every copy

    logic               w_accept;
    logic               w_bit_last;
    logic               w_gap_last;
    logic               w_last_copy;
    logic [WIDTH-1:0]   w_sel_word;
    logic               w_load;
    logic [WIDTH-1:0]   w_load_data;
    logic               w_msb;

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_bit_last  = (r_bitcnt == BIT_LAST);
    assign w_gap_last  = (r_gapcnt == GAP_LAST);
    assign w_last_copy = (r_repcnt == REPS_W'(1));
    assign w_sel_word  = use_data ? data_in : PATTERN;

`ifdef PATTERN_TX_PREAMBLE_EN
    localparam int PRE_W = $clog2(PRE_BITS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_BITS - 1);

    logic [PRE_W-1:0] r_precnt;
    logic             w_pre_last;

    assign w_pre_last = (r_precnt == PRE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_precnt <= '0;
        end else if (r_state == ST_PRE) begin
            r_precnt <= w_pre_last ? '0 : r_precnt + PRE_W'(1);
        end
    end
`endif

    // The shift register is loaded straight from the inputs on acceptance
    // and from the latched word at the end of each gap.
    assign w_load      = w_accept || ((r_state == ST_GAP) && w_gap_last);
    assign w_load_data = (r_state == ST_IDLE) ? w_sel_word : r_word;

    pattern_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (r_state == ST_SEND),
        .i_data  (w_load_data),
        .o_msb   (w_msb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bitcnt <= '0;
            r_gapcnt <= '0;
            r_repcnt <= '0;
            r_word   <= '0;
        end else begin
            if (w_accept) begin
                r_word   <= w_sel_word;
                r_repcnt <= (reps == '0) ? REPS_W'(1) : reps;
                r_bitcnt <= '0;
                r_gapcnt <= '0;
            end
            if (r_state == ST_SEND) begin
                r_bitcnt <= w_bit_last ? '0 : r_bitcnt + BIT_W'(1);
                if (w_bit_last) begin
                    r_repcnt <= r_repcnt - REPS_W'(1);
                end
            end
            if (r_state == ST_GAP) begin
                r_gapcnt <= w_gap_last ? '0 : r_gapcnt + GAP_W'(1);
            end
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
`ifdef PATTERN_TX_PREAMBLE_EN
                    w_next = ST_PRE;
`else
                    w_next = ST_SEND;
`endif
                end
            end
`ifdef PATTERN_TX_PREAMBLE_EN
            ST_PRE: begin
                if (w_pre_last) w_next = ST_SEND;
            end
`endif
            ST_SEND: begin
                if (w_bit_last) w_next = w_last_copy ? ST_DONE : ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_last) w_next = ST_SEND;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        y     = `BIT_ZERO;
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (r_state)
            ST_IDLE: ;
`ifdef PATTERN_TX_PREAMBLE_EN
            ST_PRE: busy = 1'b1;
`endif
            ST_SEND: begin
                y     = w_msb;
                valid = 1'b1;
                busy  = 1'b1;
            end
            ST_GAP:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: begin
                y     = `BIT_NONE;
                valid = 1'bx;
                busy  = 1'bx;
                done  = 1'bx;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_1101_tx.sv
// -----------------------------------------------------------------------------
// tb_pattern_1101_tx
// Self-checking bench for pattern_1101_tx. The driver pushes the expected bit
// stream and per-frame cycle counts into queues; an independent monitor pops
// and compares whenever the DUT shows valid or done.
// -----------------------------------------------------------------------------
module tb_pattern_1101_tx;

    localparam int         WIDTH   = 4;
    localparam int         GAP     = 2;
    localparam logic [3:0] PATTERN = 4'b1101;
`ifdef PATTERN_TX_PREAMBLE_EN
    localparam int         TB_PRE  = 3;
`else
    localparam int         TB_PRE  = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       use_data = 1'b0;
    logic [3:0] data_in = '0;
    logic [3:0] reps = '0;
    logic       y, valid, busy, done;

    pattern_1101_tx dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .use_data (use_data),
        .data_in  (data_in),
        .reps     (reps),
        .y        (y),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int busy_cycles;
        int idle_cycles;
        int bits;
    } frame_t;

    bit     exp_q[$];
    frame_t frame_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     mon_busy = 0;
    int     mon_idle = 0;
    int     mon_bits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame is described from the rules directly.
    function automatic void push_model(input bit ud, input logic [3:0] d, input logic [3:0] r);
        logic [3:0] word;
        int         n;
        frame_t     f;
        word = ud ? d : PATTERN;
        n    = (r == 0) ? 1 : int'(r);
        for (int c = 0; c < n; c++)
            for (int b = WIDTH - 1; b >= 0; b--)
                exp_q.push_back(word[b]);
        f.busy_cycles = n * WIDTH + (n - 1) * GAP + TB_PRE;
        f.idle_cycles = (n - 1) * GAP + TB_PRE;
        f.bits        = n * WIDTH;
        frame_q.push_back(f);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            mon_busy = 0;
            mon_idle = 0;
            mon_bits = 0;
        end else begin
            if (busy) mon_busy++;
            if (busy && !valid) mon_idle++;
            if (valid) begin
                mon_bits++;
                check("valid_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("y_bit", 32'(y), 32'(exp_q.pop_front()));
            end else begin
                check("y_zero_when_not_valid", 32'(y), 0);
            end
            if (done) begin
                frame_t f;
                check("done_not_busy", 32'(busy), 0);
                check("done_expected", 32'(frame_q.size() > 0), 1);
                if (frame_q.size() > 0) begin
                    f = frame_q.pop_front();
                    check("busy_cycles", mon_busy, f.busy_cycles);
                    check("gap_cycles", mon_idle, f.idle_cycles);
                    check("frame_bits", mon_bits, f.bits);
                end
                mon_busy = 0;
                mon_idle = 0;
                mon_bits = 0;
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at accept edge + 1.
    task automatic issue(input bit ud, input logic [3:0] d, input logic [3:0] r);
        push_model(ud, d, r);
        use_data = ud;
        data_in  = d;
        reps     = r;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        // Post-acceptance changes must not affect the frame.
        use_data = 1'($urandom);
        data_in  = 4'($urandom);
        reps     = 4'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (frame_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("frame_completed", frame_q.size(), 0);
        check("bits_drained", exp_q.size(), 0);
        frame_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;

        // Reset state
        #12;
        check("rst_y", 32'(y), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: fixed pattern, single copy, first-bit latency
        issue(1'b0, 4'b0000, 4'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid && lat < 20);
        check("first_bit_latency", lat, 1 + TB_PRE);
        wait_done(50);

        // 2: data word, three copies
        issue(1'b1, 4'b1011, 4'd3);
        wait_done(100);

        // 3: reps=0 behaves as 1; start while busy is ignored
        issue(1'b0, 4'b1111, 4'd0);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(50);
        repeat (6) @(posedge clk);
        #1;
        check("idle_after_ignored_start", 32'(busy), 0);

        // Maximum reps, no wrap-around
        issue(1'b1, 4'b1001, 4'd15);
        wait_done(300);

        // Start held high across DONE: exactly two back-to-back frames
        push_model(1'b1, 4'b0110, 4'd2);
        push_model(1'b1, 4'b0110, 4'd2);
        use_data = 1'b1;
        data_in  = 4'b0110;
        reps     = 4'd2;
        start    = 1'b1;
        lat = 0;
        while (frame_q.size() > 1 && lat < 100) begin
            @(posedge clk);
            lat++;
        end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100);

        // 4: reset during the 2nd bit of the 2nd copy
        issue(1'b1, 4'b1011, 4'd3);
        repeat (7 + TB_PRE) @(posedge clk);
        #1;
        check("pre_reset_in_send", 32'(valid), 1);
        reset = 1'b0;
        #1;
        check("abort_y", 32'(y), 0);
        check("abort_valid", 32'(valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        exp_q.delete();
        frame_q.delete();
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("no_done_after_abort", 32'(done), 0);
        issue(1'b0, 4'b0000, 4'd1);
        wait_done(50);

        // Randomized frames
        for (int i = 0; i < 12; i++) begin
            issue(1'($urandom), 4'($urandom), 4'($urandom_range(0, 6)));
            wait_done(200);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
